// File: rtl/fd_n_prog_pkg.sv
// Shared constants and config types for the programmable feedback divider.
// Optional sticky ratio-error flag is enabled by defining FD_CFG_ERR_EN.
package fd_pkg;

  localparam logic FD_MODE_PULSE = 1'b0;
  localparam logic FD_MODE_HALF  = 1'b1;
  localparam int   FD_N_MIN      = 2;
  localparam int   FD_W          = 4;

  typedef struct packed {
    logic            mode;
    logic [FD_W-1:0] n;
  } fd_cfg_t;

  // High-phase length in half-duty mode; odd ratios get the extra cycle high.
  function automatic int unsigned fd_half(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

endpackage

// File: rtl/fd_n_prog_if.sv
// Control/status bundle between the divider and whoever programs it.
// cfg_err exists only when FD_CFG_ERR_EN is defined.
interface fd_n_prog_if #(
  parameter int W = 4
);

  logic         en;
  logic [W-1:0] n_in;
  logic         mode_in;
  logic         n_load;
  logic         n_ack;
  logic         n_pend;
  logic         div_out;
  logic         tick;
`ifdef FD_CFG_ERR_EN
  logic         cfg_err;
`endif

  modport master (
    output en, n_in, mode_in, n_load,
    input  n_ack, n_pend, div_out, tick
`ifdef FD_CFG_ERR_EN
    , input cfg_err
`endif
  );

  modport slave (
    input  en, n_in, mode_in, n_load,
    output n_ack, n_pend, div_out, tick
`ifdef FD_CFG_ERR_EN
    , output cfg_err
`endif
  );

endinterface

// File: rtl/fd_cfg_shadow.sv
// Double-buffered ratio/mode config: capture with clamp, pending flag, transfer at wrap, ack.
// Macro FD_CFG_ERR_EN adds a sticky flag raised by any clamped capture.
module fd_cfg_shadow
  import fd_pkg::*;
#(
  parameter int W        = 4,
  parameter int N_RST    = 4,
  parameter int MODE_RST = 0
) (
  input  logic         clk_out,
  input  logic         rst_n,
  input  logic         n_load,
  input  logic [W-1:0] n_in,
  input  logic         mode_in,
  input  logic         wrap,
  output logic [W-1:0] act_n,
  output logic         act_mode,
  output logic [W-1:0] nxt_n,
  output logic         nxt_mode,
  output logic         n_ack,
  output logic         n_pend
`ifdef FD_CFG_ERR_EN
  , output logic       cfg_err
`endif
);

  typedef struct packed {
    logic         mode;
    logic [W-1:0] n;
  } cfg_t;

  localparam cfg_t RST_CFG = '{mode: MODE_RST[0], n: W'(N_RST)};

  cfg_t shd;
  cfg_t act;
  cfg_t act_d;
  cfg_t cap;
  logic bad;
  logic xfer;

  always_comb begin
    bad      = (n_in < W'(FD_N_MIN));
    cap.n    = bad ? W'(FD_N_MIN) : n_in;
    cap.mode = mode_in;
    xfer     = wrap & n_pend;
    act_d    = xfer ? shd : act;
  end

  // The transfer reads the old shadow, so a load on the wrap edge stays pending.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      shd    <= RST_CFG;
      act    <= RST_CFG;
      n_pend <= 1'b0;
      n_ack  <= 1'b0;
    end else begin
      act    <= act_d;
      n_ack  <= xfer;
      n_pend <= n_load | (n_pend & ~xfer);
      if (n_load) begin
        shd <= cap;
      end
    end
  end

`ifdef FD_CFG_ERR_EN
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else if (n_load && bad) begin
      cfg_err <= 1'b1;
    end
  end
`endif

  assign act_n    = act.n;
  assign act_mode = act.mode;
  assign nxt_n    = act_d.n;
  assign nxt_mode = act_d.mode;

endmodule

// File: rtl/fd_n_prog.sv
// Programmable feedback divider: divides clk_out by N in pulse or half-duty mode,
// config changes land only on period boundaries. Optional cfg_err via FD_CFG_ERR_EN.
module fd_n_prog
  import fd_pkg::*;
#(
  parameter int W        = 4,
  parameter int N_RST    = 4,
  parameter int MODE_RST = 0
) (
  input  logic        clk_out,
  input  logic        rst_n,
  fd_n_prog_if.slave  bus
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_d;
  logic [W-1:0] act_n;
  logic         act_mode;
  logic [W-1:0] nxt_n;
  logic         nxt_mode;
  logic [W:0]   half;
  logic         wrap;
  logic         div_q;
  logic         div_d;
  logic         tick_q;
  logic         tick_d;
  logic         ack;
  logic         pend;

  fd_cfg_shadow #(
    .W        (W),
    .N_RST    (N_RST),
    .MODE_RST (MODE_RST)
  ) u_shadow (
    .clk_out  (clk_out),
    .rst_n    (rst_n),
    .n_load   (bus.n_load),
    .n_in     (bus.n_in),
    .mode_in  (bus.mode_in),
    .wrap     (wrap),
    .act_n    (act_n),
    .act_mode (act_mode),
    .nxt_n    (nxt_n),
    .nxt_mode (nxt_mode),
    .n_ack    (ack),
    .n_pend   (pend)
`ifdef FD_CFG_ERR_EN
    , .cfg_err (bus.cfg_err)
`endif
  );

  // Outputs decode the next count against the next config so they line up with cnt.
  always_comb begin
    wrap   = bus.en && (cnt == act_n - W'(1));
    cnt_d  = cnt;
    if (bus.en) begin
      cnt_d = wrap ? '0 : cnt + W'(1);
    end
    half   = (W+1)'(fd_half(32'(nxt_n)));
    tick_d = (cnt_d == nxt_n - W'(1));
    if (nxt_mode == FD_MODE_HALF) begin
      div_d = ({1'b0, cnt_d} < half);
    end else begin
      div_d = ~tick_d;
    end
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      div_q  <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      cnt    <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign bus.div_out = div_q;
  assign bus.tick    = tick_q;
  assign bus.n_ack   = ack;
  assign bus.n_pend  = pend;

endmodule

// File: tb/tb_fd_n_prog.sv
// Directed + random bench for fd_n_prog against a cycle-level behavioural model.
// Checks cfg_err as well when built with FD_CFG_ERR_EN.
module tb_fd_n_prog;

  localparam int W = 4;

  logic clk_out = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  fd_n_prog_if #(.W(W)) bus ();

  fd_n_prog #(.W(W), .N_RST(4), .MODE_RST(0)) dut (
    .clk_out (clk_out),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk_out = ~clk_out;

  // Model: position in period, active ratio/mode, requested ratio/mode.
  int m_cnt, m_n, m_mode, s_n, s_mode, m_pend, m_ack, m_err, m_div, m_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_n = 4; m_mode = 0; s_n = 4; s_mode = 0;
    m_pend = 0; m_ack = 0; m_err = 0; m_div = 1; m_tick = 0;
  endtask

  task automatic model_step();
    bit at_end;
    at_end = bus.en && (m_cnt == m_n - 1);
    if (bus.en) m_cnt = at_end ? 0 : m_cnt + 1;
    m_ack = (at_end && m_pend != 0) ? 1 : 0;
    if (m_ack != 0) begin
      m_n = s_n; m_mode = s_mode; m_pend = 0;
    end
    if (bus.n_load) begin
      s_n    = (int'(bus.n_in) < 2) ? 2 : int'(bus.n_in);
      s_mode = int'(bus.mode_in);
      m_pend = 1;
      if (int'(bus.n_in) < 2) m_err = 1;
    end
    m_tick = (m_cnt == m_n - 1) ? 1 : 0;
    if (m_mode != 0) m_div = (m_cnt < (m_n + 1) / 2) ? 1 : 0;
    else             m_div = (m_tick != 0) ? 0 : 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".div"},  32'(bus.div_out), 32'(m_div));
    chk({tag, ".tick"}, 32'(bus.tick),    32'(m_tick));
    chk({tag, ".ack"},  32'(bus.n_ack),   32'(m_ack));
    chk({tag, ".pend"}, 32'(bus.n_pend),  32'(m_pend));
`ifdef FD_CFG_ERR_EN
    chk({tag, ".err"},  32'(bus.cfg_err), 32'(m_err));
`endif
  endtask

  task automatic cyc(input string tag);
    @(posedge clk_out);
    model_step();
    @(negedge clk_out);
    check_all(tag);
  endtask

  task automatic load(input int n, input int mode);
    bus.n_in = W'(n); bus.mode_in = mode[0]; bus.n_load = 1'b1;
    cyc("load");
    bus.n_load = 1'b0;
  endtask

  initial begin
    int acks;
    int guard;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.n_in = '0; bus.mode_in = 1'b0; bus.n_load = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_out);
    check_all("rst");
    rst_n = 1'b1;
    bus.en = 1'b1;

    // Reset ratio 4, pulse mode: 1,1,1,0 with tick on the low cycle.
    for (int k = 1; k <= 8; k++) begin
      cyc("n4");
      chk("pat_div",  32'(bus.div_out), ((k % 4) != 3) ? 32'd1 : 32'd0);
      chk("pat_tick", 32'(bus.tick),    ((k % 4) == 3) ? 32'd1 : 32'd0);
    end

    // Mid-period switch to N=5 half duty.
    cyc("mid");
    load(5, 1);
    repeat (15) cyc("n5h");

    // Two loads in one period: only the last applies, a single ack.
    acks = 0;
    guard = 0;
    while (m_cnt != 0 && guard < 20) begin cyc("align"); guard++; end
    load(6, 0);
    load(3, 0);
    for (int k = 0; k < 12; k++) begin
      cyc("n3");
      if (bus.n_ack) acks++;
    end
    chk("single_ack", 32'(acks), 32'd1);
    chk("n3_active", 32'(m_n), 32'd3);

    // Illegal ratio clamps to 2.
    load(0, 0);
    repeat (8) cyc("clamp");

    // Freeze at cnt=2 with a load captured while frozen.
    load(7, 0);
    repeat (8) cyc("n7");
    guard = 0;
    while (m_cnt != 2 && guard < 20) begin cyc("seek2"); guard++; end
    chk("seek2_done", 32'(m_cnt), 32'd2);
    bus.en = 1'b0;
    repeat (3) cyc("frz");
    load(4, 1);
    repeat (3) cyc("frz");
    bus.en = 1'b1;
    repeat (12) cyc("resume");

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      bus.en      = ($urandom_range(0, 9) != 0);
      bus.n_load  = ($urandom_range(0, 7) == 0);
      bus.n_in    = W'($urandom_range(0, 15));
      bus.mode_in = 1'($urandom_range(0, 1));
      cyc("rnd");
    end
    bus.n_load = 1'b0;
    bus.en = 1'b1;

    // Reset with a pending N=7 request: request is lost, no ack.
    load(7, 0);
    chk("pend_before_rst", 32'(bus.n_pend), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk_out);
    rst_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      cyc("post_rst");
      if (bus.n_ack) acks++;
    end
    chk("no_ack_after_rst", 32'(acks), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
